// File: rtl/sr_bank_arbiter_if.sv
// Request/command bundle between requesters and the SR bank arbiter.
// Requesters drive req/op/idx/clr_all; the arbiter returns gnt, sr_bus, q_shadow and its pointer.
interface sr_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDW   = 3
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     op;
  logic [NREQ*IDW-1:0] idx;
  logic                clr_all;
  logic [NREQ-1:0]     gnt;
  logic [2*NBITS-1:0]  sr_bus;
  logic [NBITS-1:0]    q_shadow;
  logic [PW-1:0]       dbg_ptr;

  modport master (
    output req, op, idx, clr_all,
    input  gnt, sr_bus, q_shadow, dbg_ptr
  );

  modport slave (
    input  req, op, idx, clr_all,
    output gnt, sr_bus, q_shadow, dbg_ptr
  );
endinterface

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter turning per-requester set/reset requests into one-cycle
// sr commands on a shared bank of SR flops, with a shadow copy of the bank.
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDW   = 3
) (
  input  logic               clk,
  input  logic               rst,
  sr_bank_arbiter_if.slave   arb
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a requester holds req (with stable op/idx) until it sees gnt[k]
  // in the cycle after its request was sampled; it must drop req or change
  // op/idx in that same cycle, otherwise the next edge samples a new request.

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NREQ);
  endfunction

  logic [PW-1:0]      ptr, ptr_nxt;
  logic [NREQ-1:0]    gnt_r, gnt_nxt;
  logic [2*NBITS-1:0] sr_r, sr_nxt;
  logic [NBITS-1:0]   q_r, q_nxt;

  logic               win_valid;
  logic [PW-1:0]      win_idx;
  logic               win_op;
  logic [IDW-1:0]     win_tgt;
  logic               tgt_ok;
  logic               redundant;

  // Search order starts at the pointer and wraps, so the last winner is tried last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!win_valid && arb.req[wrap(int'(ptr) + off)]) begin
        win_valid = 1'b1;
        win_idx   = wrap(int'(ptr) + off);
      end
    end
  end

  always_comb begin
    win_op    = arb.op[win_idx];
    win_tgt   = arb.idx[int'(win_idx)*IDW +: IDW];
    tgt_ok    = int'(win_tgt) < NBITS;
    redundant = tgt_ok && (q_r[win_tgt] == win_op);
  end

  always_comb begin
    gnt_nxt = '0;
    sr_nxt  = '0;
    q_nxt   = q_r;
    ptr_nxt = ptr;
    if (arb.clr_all) begin
      // Pending requests survive a clear; only the bank and shadow are wiped.
      sr_nxt = {NBITS{2'b01}};
      q_nxt  = '0;
    end else if (win_valid) begin
      gnt_nxt[win_idx] = 1'b1;
      ptr_nxt          = wrap(int'(win_idx) + 1);
      if (tgt_ok && !redundant) begin
        sr_nxt[2*int'(win_tgt) +: 2] = win_op ? 2'b10 : 2'b01;
        q_nxt[win_tgt]               = win_op;
      end
    end
  end

  // Reset drives reset on every lane so the bank itself clears during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r <= '0;
      sr_r  <= {NBITS{2'b01}};
      q_r   <= '0;
      ptr   <= '0;
    end else begin
      gnt_r <= gnt_nxt;
      sr_r  <= sr_nxt;
      q_r   <= q_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign arb.gnt      = gnt_r;
  assign arb.sr_bus   = sr_r;
  assign arb.q_shadow = q_r;
  assign arb.dbg_ptr  = ptr;

  a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt_r));

  for (genvar i = 0; i < NBITS; i++) begin : g_lane_chk
    a_no_11: assert property (@(posedge clk) sr_r[2*i+1:2*i] != 2'b11);
  end
endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter: hand-computed grants, sr lanes, shadow and bank state.
module tb_sr_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IDW   = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] exp_q[$];
  logic [31:0] exp_sr_q[$];
  logic [31:0] exp_sh_q[$];
  logic [NBITS-1:0] bank;

  sr_bank_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS), .IDW(IDW)) arb ();

  sr_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SR bank fed by the command bus.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBITS; i++) begin
      if (arb.sr_bus[2*i+1])      bank[i] <= 1'b1;
      else if (arb.sr_bus[2*i])   bank[i] <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ-1:0] o,
                       input logic [NREQ*IDW-1:0] ix, input logic c);
    arb.req     = r;
    arb.op      = o;
    arb.idx     = ix;
    arb.clr_all = c;
  endtask

  function automatic logic [31:0] lane11(input logic [2*NBITS-1:0] s);
    return 32'(s & (s >> 1) & {NBITS{2'b01}});
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive('0, '0, '0, 1'b0);

    // Reset
    step();
    step();
    check_eq("rst_gnt", 32'(arb.gnt), 32'h0);
    check_eq("rst_q", 32'(arb.q_shadow), 32'h00);
    check_eq("rst_sr", 32'(arb.sr_bus), 32'h5555);
    check_eq("rst_ptr", 32'(arb.dbg_ptr), 32'h0);
    rst = 1'b0;
    check_eq("rst_tail_sr", 32'(arb.sr_bus), 32'h5555);
    step();
    check_eq("post_rst_sr", 32'(arb.sr_bus), 32'h0000);
    check_eq("post_rst_bank", 32'(bank), 32'h00);

    // Single set: requester 0 sets bit 5
    drive(4'b0001, 4'b0001, 12'(5), 1'b0);
    step();
    check_eq("set_gnt", 32'(arb.gnt), 32'h1);
    check_eq("set_sr", 32'(arb.sr_bus), 32'h0800);
    check_eq("set_q", 32'(arb.q_shadow), 32'h20);
    drive('0, '0, '0, 1'b0);
    step();
    check_eq("set_idle_gnt", 32'(arb.gnt), 32'h0);
    check_eq("set_bank", 32'(bank), 32'h20);
    check_eq("set_ptr", 32'(arb.dbg_ptr), 32'h1);

    // Redundant set of bit 5 by requester 2, then a real reset of it
    drive(4'b0100, 4'b0100, 12'(5 << 6), 1'b0);
    step();
    check_eq("red_gnt", 32'(arb.gnt), 32'h4);
    check_eq("red_sr", 32'(arb.sr_bus), 32'h0000);
    check_eq("red_q", 32'(arb.q_shadow), 32'h20);
    drive(4'b0100, 4'b0000, 12'(5 << 6), 1'b0);
    step();
    check_eq("rclr_gnt", 32'(arb.gnt), 32'h4);
    check_eq("rclr_sr", 32'(arb.sr_bus), 32'h0400);
    check_eq("rclr_q", 32'(arb.q_shadow), 32'h00);
    drive('0, '0, '0, 1'b0);
    step();
    check_eq("rclr_bank", 32'(bank), 32'h00);
    check_eq("rclr_ptr", 32'(arb.dbg_ptr), 32'h3);

    // Mid-operation reset: grant to requester 3 discarded by reset
    drive(4'b1000, 4'b1000, 12'(7 << 9), 1'b0);
    step();
    check_eq("mid_gnt", 32'(arb.gnt), 32'h8);
    check_eq("mid_sr", 32'(arb.sr_bus), 32'h8000);
    check_eq("mid_q", 32'(arb.q_shadow), 32'h80);
    rst = 1'b1;
    drive('0, '0, '0, 1'b0);
    step();
    check_eq("mid_rst_gnt", 32'(arb.gnt), 32'h0);
    check_eq("mid_rst_sr", 32'(arb.sr_bus), 32'h5555);
    check_eq("mid_rst_q", 32'(arb.q_shadow), 32'h00);
    check_eq("mid_rst_ptr", 32'(arb.dbg_ptr), 32'h0);
    rst = 1'b0;
    step();
    check_eq("mid_rel_sr", 32'(arb.sr_bus), 32'h0000);
    check_eq("mid_rel_bank", 32'(bank), 32'h00);

    // Round robin: all four set bit k; fifth grant is redundant
    exp_q    = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
    exp_sr_q = '{32'h0002, 32'h0008, 32'h0020, 32'h0080, 32'h0000};
    exp_sh_q = '{32'h01, 32'h03, 32'h07, 32'h0F, 32'h0F};
    drive(4'b1111, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0);
    for (int n = 0; n < 5; n++) begin
      step();
      check_eq($sformatf("rr_gnt%0d", n), 32'(arb.gnt), exp_q.pop_front());
      check_eq($sformatf("rr_sr%0d", n), 32'(arb.sr_bus), exp_sr_q.pop_front());
      check_eq($sformatf("rr_q%0d", n), 32'(arb.q_shadow), exp_sh_q.pop_front());
      check_eq($sformatf("rr_no11_%0d", n), lane11(arb.sr_bus), 32'h0);
    end
    drive('0, '0, '0, 1'b0);
    step();
    check_eq("rr_idle_gnt", 32'(arb.gnt), 32'h0);
    check_eq("rr_bank", 32'(bank), 32'h0F);
    check_eq("rr_ptr", 32'(arb.dbg_ptr), 32'h1);

    // clr_all collides with a request from requester 1 (set bit 1)
    drive(4'b0010, 4'b0010, 12'(1 << 3), 1'b1);
    step();
    check_eq("clr_sr", 32'(arb.sr_bus), 32'h5555);
    check_eq("clr_gnt", 32'(arb.gnt), 32'h0);
    check_eq("clr_q", 32'(arb.q_shadow), 32'h00);
    check_eq("clr_ptr", 32'(arb.dbg_ptr), 32'h1);
    arb.clr_all = 1'b0;
    step();
    check_eq("clr_next_gnt", 32'(arb.gnt), 32'h2);
    check_eq("clr_next_sr", 32'(arb.sr_bus), 32'h0008);
    check_eq("clr_next_q", 32'(arb.q_shadow), 32'h02);
    drive('0, '0, '0, 1'b0);
    step();
    check_eq("clr_bank", 32'(bank), 32'h02);

    // Idle holds state
    step();
    step();
    check_eq("idle_gnt", 32'(arb.gnt), 32'h0);
    check_eq("idle_sr", 32'(arb.sr_bus), 32'h0000);
    check_eq("idle_q", 32'(arb.q_shadow), 32'h02);
    check_eq("idle_ptr", 32'(arb.dbg_ptr), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sr_bank_arbiter.md
Name: sr_bank_arbiter

Overview:
- Shares a bank of NBITS sr_ff-style set/reset flops between NREQ requesters.
- Each requester asks to set or reset one bit of the bank. A round-robin arbiter grants at most one request per cycle.
- The granted request becomes a one-cycle 2-bit sr command on that bit's lane. Encoding: 2'b10 = set, 2'b01 = reset, 2'b00 = hold.
- The forbidden 2'b11 code is never driven. A shadow copy of the bank state is kept for requesters and status logic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NBITS, 8, number of SR flops in the bank.
- IDW, 3, bit-index width; must equal ceil(log2(NBITS)).

Ports:
- clk  in  1  rising-edge clock for the controller and the SR bank.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held high until granted.
- op  in  NREQ  per-requester operation: 1 = set, 0 = reset.
- idx  in  NREQ*IDW  per-requester target bit; requester k uses idx[k*IDW +: IDW].
- clr_all  in  1  one-cycle pulse; clears the whole bank.
- gnt  out  NREQ  one-hot grant, registered, one cycle wide.
- sr_bus  out  2*NBITS  registered sr command per bit. Lane i is sr_bus[2*i+1:2*i]; the upper bit is s, the lower bit is r.
- q_shadow  out  NBITS  controller's copy of the bank state.

Behaviour:
- All outputs are registered and all state updates on the rising edge of clk.
- Reset: while rst=1, at each edge:
  - gnt <= 0; q_shadow <= 0; round-robin pointer <= 0.
  - sr_bus <= 2'b01 on every lane, so the bank clears during reset.
  - The first cycle after rst falls still shows the all-01 value, which clears again harmlessly. From the next edge on, normal operation applies.
- Default: every lane of sr_bus is 2'b00 and gnt = 0 unless a command is issued below.
- clr_all (rst=0): takes priority over requests.
  - Next cycle: every lane = 2'b01, gnt = 0, q_shadow <= 0 at the same edge.
  - Pending requests stay pending; the pointer is unchanged.
- Arbitration when clr_all=0 and any req=1:
  - Search starts at the pointer and wraps NREQ-1 -> 0. The first requester found is granted.
  - The pointer <= granted index + 1, modulo NREQ.
- Issue, for a grant to requester k:
  - Next cycle gnt[k]=1.
  - Lane idx_k = 2'b10 if op_k=1, else 2'b01; all other lanes = 2'b00.
  - q_shadow[idx_k] <= op_k at the same edge.
- Redundant command (op_k equals the current q_shadow[idx_k]):
  - Still granted and the pointer still advances.
  - The lane drives 2'b00 and q_shadow is unchanged.
- Invalid target (idx_k >= NBITS): granted, no lane driven, q_shadow unchanged.
- Requester handshake:
  - A requester sees gnt[k]=1 in the cycle after its request was sampled.
  - It must drop req or change op/idx in that same cycle, otherwise it is treated as a new request.
  - The arbiter never grants the same requester in two consecutive cycles while another requester has req=1.
- Latency:
  - Request sampled in cycle N; gnt and sr_bus are valid in N+1.
  - The bank flop updates at the edge ending N+1; q_shadow updates at the edge ending N. Bank q and q_shadow therefore agree from N+2 onward.
- Invariants:
  - Exactly zero or one lane is non-zero, except during clr_all and reset.
  - No lane is ever 2'b11; popcount(gnt) <= 1.
- Reset mid-operation: a grant in flight is discarded. The rst=1 edge overrides gnt/sr_bus/q_shadow with the reset values, and the requester must re-request.
- Idle (no req, no clr_all): sr_bus all 00, gnt=0, state held.

Test Plan:
- Reset: rst=1 for 2 cycles -> gnt=0, q_shadow=8'h00, every sr_bus lane 2'b01; one cycle after release all lanes 2'b00.
- Single set: req=4'b0001, op[0]=1, idx0=5 at cycle N -> cycle N+1 gnt=4'b0001, sr_bus lane5=2'b10, others 00; q_shadow=8'h20; bank q[5]=1 at N+2.
- Round-robin: req=4'b1111 held, all op=1, idx k=k -> grants 0001,0010,0100,1000,0001 in successive cycles; q_shadow reaches 8'h0F; no lane ever 11.
- Redundant: q_shadow=8'h20, requester 2 sets bit 5 -> gnt[2]=1, all lanes 00, q_shadow stays 8'h20; a following reset of bit 5 drives lane5=01 and q_shadow=8'h00.
- clr_all collision: clr_all=1 and req=4'b0010 in the same cycle -> next cycle all lanes 01, gnt=0, q_shadow=8'h00; the following cycle gnt=4'b0010.
- Mid-op reset: request granted in cycle N, rst=1 at the edge ending N+1 -> outputs at reset values, q_shadow=8'h00, pointer=0.
